// File: rtl/vq_topk_select.sv
// Top-K element selector for the DAC mismatch-shaping path.
// Picks the K largest of 18 weights, one per clock, lowest index on ties.
module vq_topk_select #(
  parameter int N_EL = 18,
  parameter int W    = 7,
  parameter int KW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k_in,
  input  logic [N_EL*W-1:0] w_in,
  output logic              busy,
  output logic              pick_valid,
  output logic [4:0]        pick_idx,
  output logic [W-1:0]      pick_val,
  output logic [N_EL-1:0]   sel_mask,
  output logic              done
);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t state, state_nx;

  logic [N_EL-1:0][W-1:0] wr;
  logic [KW-1:0]          keff;
  logic [KW-1:0]          cnt;
  logic [KW-1:0]          cnt_inc;
  logic [KW-1:0]          kclamp;
  logic [4:0]             best_i;
  logic [W-1:0]           best_v;
  logic                   found;
  logic                   take;
  logic                   fin;
  logic                   accept;

  assign busy    = (state == SEARCH);
  assign cnt_inc = cnt + 1'b1;
  assign kclamp  = (k_in > KW'(N_EL)) ? KW'(N_EL) : k_in;

  // Masked argmax; strict '>' keeps the lowest index on ties.
  always_comb begin
    best_i = '0;
    best_v = '0;
    found  = 1'b0;
    for (int i = 0; i < N_EL; i++) begin
      if (!sel_mask[i] && (!found || wr[i] > best_v)) begin
        found  = 1'b1;
        best_v = wr[i];
        best_i = 5'(i);
      end
    end
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    fin      = 1'b0;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = SEARCH;
        end
      end
      SEARCH: begin
        if (cnt == keff) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end else begin
          take = 1'b1;
          if (cnt_inc == keff) begin
            fin      = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr         <= '0;
      keff       <= '0;
      cnt        <= '0;
      sel_mask   <= '0;
      pick_valid <= 1'b0;
      pick_idx   <= '0;
      pick_val   <= '0;
      done       <= 1'b0;
    end else begin
      pick_valid <= take;
      done       <= fin;
      if (accept) begin
        wr       <= w_in;
        keff     <= kclamp;
        cnt      <= '0;
        sel_mask <= '0;
      end
      if (take) begin
        sel_mask <= sel_mask | (N_EL'(1) << best_i);
        pick_idx <= best_i;
        pick_val <= best_v;
        cnt      <= cnt_inc;
      end
    end
  end

endmodule
